// File: rtl/truth_table_sweeper_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_pkg : shared encodings for the truth-table sweeper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package truth_table_sweeper_pkg;

  localparam int N_VECTORS = 16;
  localparam int VEC_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/truth_table_sweeper_slice.sv
// ---------------------------------------------------------------------------
// tt_sweep_slice : per-implementation truth-table capture and sticky mismatch
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_sweep_slice
  import truth_table_sweeper_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VEC_W-1:0]     vec,
  input  logic                 sample_en,
  input  logic                 clear,
  input  logic                 impl_bit,
  input  logic                 exp_bit,
  output logic [N_VECTORS-1:0] cap,
  output logic                 mis,
  output logic                 sticky
);

  logic [N_VECTORS-1:0] cap_q, cap_d;
  logic                 sticky_q, sticky_d;

  assign mis    = impl_bit ^ exp_bit;
  assign cap    = cap_q;
  assign sticky = sticky_q;

  always_comb begin
    cap_d    = cap_q;
    sticky_d = sticky_q;
    if (clear) begin
      cap_d    = '0;
      sticky_d = 1'b0;
    end else if (sample_en) begin
      cap_d[vec] = impl_bit;
      sticky_d   = sticky_q | mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper : exhaustive 4-input sweep checking N_IMPL implementations
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IMPL = 6,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          expected,
  output logic [3:0]           vec,
  input  logic [N_IMPL-1:0]    impl_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IMPL-1:0]    fail_mask,
  output logic [3:0]           first_fail_vec,
  output logic                 first_fail_vld,
  input  logic [3:0]           tt_sel,
  output logic [15:0]          tt_out
);

  localparam int                 CNT_W       = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0]   LAST_VEC    = VEC_W'(N_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_VECTORS-1:0]   exp_q, exp_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [VEC_W-1:0]       ffv_q, ffv_d;
  logic                   ffvld_q, ffvld_d;

  logic                   sample_en;
  logic                   clear_caps;
  logic [N_IMPL-1:0]      mis_w;
  logic [N_IMPL-1:0]      sticky_w;
  logic [N_VECTORS-1:0]   cap_w [N_IMPL];

  assign vec            = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_mask      = sticky_w;
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffvld_q;

  generate
    for (genvar k = 0; k < N_IMPL; k++) begin : g_slice
      tt_sweep_slice u_slice (
        .clk       (clk),
        .reset     (reset),
        .vec       (vec_q),
        .sample_en (sample_en),
        .clear     (clear_caps),
        .impl_bit  (impl_out[k]),
        .exp_bit   (exp_q[vec_q]),
        .cap       (cap_w[k]),
        .mis       (mis_w[k]),
        .sticky    (sticky_w[k])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    ffv_d      = ffv_q;
    ffvld_d    = ffvld_q;
    sample_en  = 1'b0;
    clear_caps = 1'b0;

    // Abort wins over everything except IDLE; partial results stay visible.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            exp_d      = expected;
            clear_caps = 1'b1;
            pass_d     = 1'b0;
            ffvld_d    = 1'b0;
            vec_d      = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          sample_en = 1'b1;
          if ((|mis_w) && !ffvld_q) begin
            ffv_d   = vec_q;
            ffvld_d = 1'b1;
          end
          if (vec_q == LAST_VEC) begin
            done_d  = 1'b1;
            pass_d  = ~|(sticky_w | mis_w);
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
    end
  end

  always_comb begin
    tt_out = '0;
    for (int k = 0; k < N_IMPL; k++) begin
      if (tt_sel == VEC_W'(k)) tt_out = cap_w[k];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper : vector-table and randomized bench for the sweeper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_truth_table_sweeper;

  localparam int NI = 6;

  typedef struct {
    logic [15:0]          exp;
    logic [NI-1:0][15:0]  tt;
    logic                 pass;
    logic [NI-1:0]        fmask;
    logic [3:0]           ffv;
    logic                 ffvld;
  } rec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start_v  [2];
  logic                abort_v  [2];
  logic [15:0]         exp_v    [2];
  logic [3:0]          vec_v    [2];
  logic [NI-1:0]       impl_v   [2];
  logic                busy_v   [2];
  logic                done_v   [2];
  logic                pass_v   [2];
  logic [NI-1:0]       fmask_v  [2];
  logic [3:0]          ffv_v    [2];
  logic                ffvld_v  [2];
  logic [3:0]          sel_v    [2];
  logic [15:0]         ttout_v  [2];
  logic [NI-1:0][15:0] tt_v     [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IMPL(NI), .SETTLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
    .expected(exp_v[0]), .vec(vec_v[0]), .impl_out(impl_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_mask(fmask_v[0]), .first_fail_vec(ffv_v[0]),
    .first_fail_vld(ffvld_v[0]), .tt_sel(sel_v[0]), .tt_out(ttout_v[0])
  );

  truth_table_sweeper #(.N_IMPL(NI), .SETTLE(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
    .expected(exp_v[1]), .vec(vec_v[1]), .impl_out(impl_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_mask(fmask_v[1]), .first_fail_vec(ffv_v[1]),
    .first_fail_vld(ffvld_v[1]), .tt_sel(sel_v[1]), .tt_out(ttout_v[1])
  );

  // Each implementation is just its truth table looked up by the driven vector.
  always_comb begin
    impl_v[0] = '0;
    impl_v[1] = '0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NI; k++)
        impl_v[d][k] = tt_v[d][k][vec_v[d]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic rec_t model(input logic [15:0] e, input logic [NI-1:0][15:0] t);
    rec_t r;
    r.exp = e; r.tt = t; r.fmask = '0; r.ffv = '0; r.ffvld = 1'b0;
    for (int k = 0; k < NI; k++) r.fmask[k] = (t[k] != e);
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < NI; k++)
        if (!r.ffvld && (t[k][i] != e[i])) begin
          r.ffvld = 1'b1;
          r.ffv   = 4'(i);
        end
    r.pass = (r.fmask == '0);
    return r;
  endfunction

  task automatic run(input int d, input rec_t r, input int settle);
    int cyc;
    tt_v[d]  = r.tt;
    exp_v[d] = r.exp;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    exp_v[d]   = ~r.exp;
    chk("busy_after_accept", 32'(busy_v[d]), 32'd1);
    cyc = 0;
    while (!done_v[d] && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", cyc, 16 * (settle + 1));
    chk("busy_at_done", 32'(busy_v[d]), 32'd1);
    chk("pass", 32'(pass_v[d]), 32'(r.pass));
    chk("fail_mask", 32'(fmask_v[d]), 32'(r.fmask));
    chk("first_fail_vld", 32'(ffvld_v[d]), 32'(r.ffvld));
    if (r.ffvld) chk("first_fail_vec", 32'(ffv_v[d]), 32'(r.ffv));
    @(posedge clk); #1;
    chk("done_pulse_width", 32'(done_v[d]), 32'd0);
    chk("busy_after_done", 32'(busy_v[d]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("pass_held", 32'(pass_v[d]), 32'(r.pass));
    for (int k = 0; k < NI; k++) begin
      sel_v[d] = 4'(k);
      #1;
      chk("tt_out", 32'(ttout_v[d]), 32'(r.tt[k]));
    end
  endtask

  rec_t recs[$];
  rec_t r;
  logic [NI-1:0][15:0] t;
  logic [15:0] e;
  int seen;

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0; exp_v[d] = '0; sel_v[d] = '0; tt_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_vec", 32'(vec_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_done", 32'(done_v[0]), 0);
    chk("rst_pass", 32'(pass_v[0]), 0);
    chk("rst_fail_mask", 32'(fmask_v[0]), 0);
    chk("rst_ffvld", 32'(ffvld_v[0]), 0);
    chk("rst_tt_out", 32'(ttout_v[0]), 0);

    // Directed records: all-correct, impl 3 stuck at 0, impl 5 wrong only at vector 13.
    r.exp = 16'h212F; r.tt = {NI{16'h212F}};
    r.pass = 1'b1; r.fmask = '0; r.ffv = '0; r.ffvld = 1'b0;
    recs.push_back(r);
    r.tt[3] = 16'h0000; r.pass = 1'b0; r.fmask = 6'b001000; r.ffv = 4'd0; r.ffvld = 1'b1;
    recs.push_back(r);
    r.tt = {NI{16'h212F}}; r.tt[5] = 16'h012F;
    r.fmask = 6'b100000; r.ffv = 4'd13; r.ffvld = 1'b1;
    recs.push_back(r);
    for (int n = 0; n < 6; n++) begin
      e = 16'($urandom);
      for (int k = 0; k < NI; k++) begin
        case ($urandom_range(0, 3))
          0, 1: t[k] = e;
          2:    t[k] = e ^ (16'h1 << $urandom_range(0, 15));
          default: t[k] = 16'($urandom);
        endcase
      end
      recs.push_back(model(e, t));
    end
    for (int i = 0; i < recs.size(); i++) run(0, recs[i], 1);

    sel_v[0] = 4'd6;
    #1;
    chk("tt_out_sel_out_of_range", 32'(ttout_v[0]), 0);

    // start together with abort in IDLE is not accepted.
    @(negedge clk);
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("start_abort_idle_busy", 32'(busy_v[0]), 0);

    // Abort mid-sweep; a start while busy must not restart the sweep.
    tt_v[0] = {NI{16'h212F}}; tt_v[0][3] = 16'h0000; exp_v[0] = 16'h212F;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("start_while_busy_vec", 32'(vec_v[0]), 3);
    repeat (4) @(posedge clk);
    #1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    chk("abort_busy", 32'(busy_v[0]), 0);
    chk("abort_vec", 32'(vec_v[0]), 0);
    chk("abort_pass", 32'(pass_v[0]), 0);
    chk("abort_partial_fail_mask", 32'(fmask_v[0]), 32'b001000);
    chk("abort_partial_ffvld", 32'(ffvld_v[0]), 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    chk("no_activity_after_abort", seen, 0);

    // Reset while vec=7: everything returns to zero immediately.
    tt_v[0] = {NI{16'h212F}};
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_vec", 32'(vec_v[0]), 7);
    reset = 1'b1;
    sel_v[0] = 4'd0;
    #1;
    chk("mid_reset_vec", 32'(vec_v[0]), 0);
    chk("mid_reset_busy", 32'(busy_v[0]), 0);
    chk("mid_reset_fail_mask", 32'(fmask_v[0]), 0);
    chk("mid_reset_ffv", 32'(ffv_v[0]), 0);
    chk("mid_reset_ffvld", 32'(ffvld_v[0]), 0);
    chk("mid_reset_tt_out", 32'(ttout_v[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, recs[0], 1);

    // Longer settle on the second instance.
    run(1, recs[2], 3);
    run(1, recs[3], 3);
    sel_v[1] = 4'd7;
    #1;
    chk("settle3_tt_out_sel7", 32'(ttout_v[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
